// File: rtl/seg7_pkg.sv
// Shared constants, glyph table and FSM states
// for the multiplexed 7-segment display driver.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low {g,f,e,d,c,b,a}; entry k is the glyph for nibble k.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_COMMIT
  } state_t;

endpackage

// File: rtl/seg7_hex_decoder.sv
// Nibble to active-low segment pattern,
// with dash taking priority over blank.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_GLYPH[digit];
    unique case (1'b1)
      dash:           seg = SEG_DASH;
      blank && !dash: seg = SEG_BLANK;
      default:        seg = HEX_GLYPH[digit];
    endcase
  end

endmodule

// File: rtl/seg7_mux_display.sv
// Binary-to-BCD/hex converter with a scanned,
// time-multiplexed 7-segment output stage.
module seg7_mux_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DATA_W      = 8,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     value,
  input  logic                  load,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic [6:0]            seg_n,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  localparam int BCD_W = NUM_DIGITS * 4;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t state, state_nx;

  logic [DATA_W-1:0] bin_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [BCD_W-1:0]  adj;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_acc;
  logic              blz_q;
  logic [BCD_W-1:0]  disp_q;
  logic              disp_blz;
  logic [PRE_W-1:0]  presc;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        sel_digit;
  logic              upper_zero;
  logic              blank_c;
  logic [6:0]        seg_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (load) state_nx = hex_mode ? S_COMMIT : S_CONV;
      S_CONV:
        if (cnt_q == CNT_W'(DATA_W - 1)) state_nx = S_COMMIT;
      S_COMMIT:
        state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

  // Add-3 correction applied to every BCD digit before each shift.
  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5)
        adj[4*k +: 4] = 4'(bcd_q[4*k +: 4] + 4'd3);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      ovf_acc  <= 1'b0;
      blz_q    <= 1'b0;
      disp_q   <= '0;
      disp_blz <= 1'b0;
      ovf      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: if (load) begin
          bin_q   <= value;
          blz_q   <= blank_lz;
          cnt_q   <= '0;
          ovf_acc <= 1'b0;
          bcd_q   <= hex_mode ? BCD_W'(value) : '0;
        end
        S_CONV: begin
          bcd_q   <= {adj[BCD_W-2:0], bin_q[DATA_W-1]};
          bin_q   <= bin_q << 1;
          ovf_acc <= ovf_acc | adj[BCD_W-1];
          cnt_q   <= cnt_q + 1'b1;
        end
        S_COMMIT: begin
          disp_q   <= bcd_q;
          disp_blz <= blz_q;
          ovf      <= ovf_acc;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A digit is blank when it and every digit above it are zero.
  always_comb begin
    sel_digit  = disp_q[int'(idx)*4 +: 4];
    upper_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(idx) && disp_q[4*k +: 4] != 4'd0)
        upper_zero = 1'b0;
    end
    blank_c = disp_blz && (idx != '0) && upper_zero;
  end

  seg7_hex_decoder u_dec (
    .digit (sel_digit),
    .blank (blank_c),
    .dash  (ovf),
    .seg   (seg_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
      seg_n <= SEG_BLANK;
      an_n  <= '1;
    end else begin
      if (presc == PRE_W'(REFRESH_DIV - 1)) begin
        presc <= '0;
        idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      seg_n <= seg_c;
      an_n  <= ~(NUM_DIGITS'(1) << idx);
    end
  end

endmodule

// File: tb/tb_seg7_mux_display.sv
// Directed bench for seg7_mux_display: a 4-digit
// and a 2-digit instance share the same stimulus.
module tb_seg7_mux_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] value = '0;
  logic       load = 1'b0;
  logic       hex_mode = 1'b0;
  logic       blank_lz = 1'b0;

  logic [6:0] seg_n, seg2;
  logic [3:0] an_n;
  logic [1:0] an2;
  logic       busy, done, ovf;
  logic       busy2, done2, ovf2;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int lat;
  int waitc;
  logic [6:0] g4 [4];
  logic [6:0] g2 [2];
  logic [3:0] an_seq [4];

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  seg7_mux_display #(
    .NUM_DIGITS(4), .DATA_W(8), .REFRESH_DIV(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .hex_mode(hex_mode), .blank_lz(blank_lz),
    .seg_n(seg_n), .an_n(an_n), .busy(busy),
    .done(done), .ovf(ovf)
  );

  seg7_mux_display #(
    .NUM_DIGITS(2), .DATA_W(8), .REFRESH_DIV(4)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .hex_mode(hex_mode), .blank_lz(blank_lz),
    .seg_n(seg2), .an_n(an2), .busy(busy2),
    .done(done2), .ovf(ovf2)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input logic [7:0] v, input logic hx,
                          input logic bz, output int l);
    value    = v;
    hex_mode = hx;
    blank_lz = bz;
    load     = 1'b1;
    tick();
    load = 1'b0;
    l = 1;
    while (!done && l < 100) begin
      tick();
      l++;
    end
  endtask

  task automatic capture();
    for (int k = 0; k < 4; k++) g4[k] = 'x;
    for (int k = 0; k < 2; k++) g2[k] = 'x;
    repeat (24) begin
      tick();
      for (int k = 0; k < 4; k++)
        if (an_n === ~(4'(1) << k)) g4[k] = seg_n;
      for (int k = 0; k < 2; k++)
        if (an2 === ~(2'(1) << k)) g2[k] = seg2;
    end
  endtask

  initial begin
    an_seq[0] = 4'hD;
    an_seq[1] = 4'hB;
    an_seq[2] = 4'h7;
    an_seq[3] = 4'hE;

    // reset values
    tick();
    tick();
    check("rst_seg", 32'(seg_n), 32'h7F);
    check("rst_an", 32'(an_n), 32'hF);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ovf", 32'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // test 1: idle display "0000", scan order
    waitc = 0;
    tick();
    while (an_n !== 4'hD && waitc < 20) begin
      tick();
      waitc++;
    end
    check("scan_sync", 32'(an_n), 32'hD);
    for (int j = 0; j < 4; j++) begin
      for (int r = 0; r < 4; r++) begin
        if (j != 0 || r != 0) tick();
        check("scan_an", 32'(an_n), 32'(an_seq[j]));
        check("scan_seg", 32'(seg_n), 32'h40);
      end
    end

    // test 2: 225 decimal, blanking
    run_load(8'd225, 1'b0, 1'b1, lat);
    check("dec_lat", 32'(lat), 10);
    check("dec_ovf", 32'(ovf), 0);
    capture();
    check("dec_d0", 32'(g4[0]), 32'h12);
    check("dec_d1", 32'(g4[1]), 32'h24);
    check("dec_d2", 32'(g4[2]), 32'h24);
    check("dec_d3", 32'(g4[3]), 32'h7F);

    // test 3: 0xAF hex, no blanking
    run_load(8'hAF, 1'b1, 1'b0, lat);
    check("hex_lat", 32'(lat), 2);
    check("hex_ovf", 32'(ovf), 0);
    capture();
    check("hex_d0", 32'(g4[0]), 32'h0E);
    check("hex_d1", 32'(g4[1]), 32'h08);
    check("hex_d2", 32'(g4[2]), 32'h40);
    check("hex_d3", 32'(g4[3]), 32'h40);

    // test 4: two-digit overflow then recovery
    run_load(8'd150, 1'b0, 1'b0, lat);
    capture();
    check("ovf_flag", 32'(ovf2), 1);
    check("ovf_d0", 32'(g2[0]), 32'h3F);
    check("ovf_d1", 32'(g2[1]), 32'h3F);
    run_load(8'd99, 1'b0, 1'b0, lat);
    capture();
    check("n99_flag", 32'(ovf2), 0);
    check("n99_d0", 32'(g2[0]), 32'h10);
    check("n99_d1", 32'(g2[1]), 32'h10);

    // test 5: load while busy is ignored
    done_cnt = 0;
    value    = 8'd37;
    hex_mode = 1'b0;
    blank_lz = 1'b0;
    load     = 1'b1;
    tick();
    load = 1'b0;
    check("busy_conv", 32'(busy), 1);
    tick();
    tick();
    value = 8'd99;
    load  = 1'b1;
    tick();
    load = 1'b0;
    lat  = 4;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    check("ign_lat", 32'(lat), 10);
    capture();
    check("ign_pulses", 32'(done_cnt), 1);
    check("ign_d0", 32'(g4[0]), 32'h78);
    check("ign_d1", 32'(g4[1]), 32'h30);
    check("ign_d2", 32'(g4[2]), 32'h40);
    check("ign_d3", 32'(g4[3]), 32'h40);

    // test 6: reset mid-conversion
    run_load(8'd150, 1'b0, 1'b0, lat);
    tick();
    check("pre_rst_ovf2", 32'(ovf2), 1);
    value = 8'd200;
    load  = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_seg", 32'(seg_n), 32'h7F);
    check("arst_an", 32'(an_n), 32'hF);
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("arst_ovf2", 32'(ovf2), 0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    capture();
    check("post_busy", 32'(busy), 0);
    check("post_done_cnt", 32'(done_cnt), 0);
    check("post_d0", 32'(g4[0]), 32'h40);
    check("post_d1", 32'(g4[1]), 32'h40);
    check("post_d2", 32'(g4[2]), 32'h40);
    check("post_d3", 32'(g4[3]), 32'h40);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
